// File: rtl/mant_mul_seq.sv
// mant_mul_seq: multi-cycle unsigned mantissa multiplier (N_LIMB*8 x N_LIMB*8).
// Time-shares one 8x8 Vedic core, one limb-pair partial product per cycle,
// shifted and accumulated into a 2*WIDTH-bit result. Valid/ready on both sides.
// Optional build macro: MANT_MUL_EARLY_ZERO_EN (zero operand skips the MUL phase).

// 8x8 unsigned Vedic multiplier: four 4x4 vertical/crosswise products summed.
module Vedic_8_x_8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] prod
);
  logic [7:0] q_ll, q_hl, q_lh, q_hh;

  assign q_ll = 8'(a[3:0]) * 8'(b[3:0]);
  assign q_hl = 8'(a[7:4]) * 8'(b[3:0]);
  assign q_lh = 8'(a[3:0]) * 8'(b[7:4]);
  assign q_hh = 8'(a[7:4]) * 8'(b[7:4]);

  // Combine the four sub-products at their nibble weights.
  always_comb begin
    prod = 16'(q_ll) + (16'(q_hl) << 4) + (16'(q_lh) << 4) + (16'(q_hh) << 8);
  end
endmodule

module mant_mul_seq #(
  parameter int unsigned N_LIMB = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*N_LIMB-1:0]   a,
  input  logic [8*N_LIMB-1:0]   b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [16*N_LIMB-1:0]  product,
  output logic                  busy
);
  localparam int unsigned WIDTH  = 8 * N_LIMB;
  localparam int unsigned ACC_W  = 2 * WIDTH;
  localparam int unsigned NSTEP  = N_LIMB * N_LIMB;
  localparam int unsigned STEP_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam int unsigned IDX_W  = (N_LIMB > 1) ? $clog2(N_LIMB) : 1;
  localparam int unsigned SH_W   = $clog2(ACC_W);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t            state_q;
  logic [WIDTH-1:0]  a_q, b_q;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [STEP_W-1:0] step_q;
  logic [IDX_W-1:0]  i_q, j_q;
  logic              in_ready_q, out_valid_q, busy_q;

  logic [7:0]        core_a_c, core_b_c;
  logic [15:0]       p16_c;
  logic [SH_W-1:0]   shamt_c;

  // Limb selection for the current step: i walks a's limbs, j walks b's limbs.
  always_comb begin
    core_a_c = a_q[{i_q, 3'b000} +: 8];
    core_b_c = b_q[{j_q, 3'b000} +: 8];
    shamt_c  = (SH_W'(i_q) + SH_W'(j_q)) << 3;
    acc_d    = acc_q + (ACC_W'(p16_c) << shamt_c);
  end

  Vedic_8_x_8 u_core (
    .a    (core_a_c),
    .b    (core_b_c),
    .prod (p16_c)
  );

  // Control FSM, step/limb counters, accumulator and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      step_q      <= '0;
      i_q         <= '0;
      j_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= b;
            acc_q      <= '0;
            step_q     <= '0;
            i_q        <= '0;
            j_q        <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
`ifdef MANT_MUL_EARLY_ZERO_EN
            if (a == '0 || b == '0) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= MUL;
            end
`else
            state_q <= MUL;
`endif
          end
        end
        MUL: begin
          acc_q  <= acc_d;
          step_q <= step_q + STEP_W'(1);
          if (j_q == IDX_W'(N_LIMB - 1)) begin
            j_q <= '0;
            i_q <= i_q + IDX_W'(1);
          end else begin
            j_q <= j_q + IDX_W'(1);
          end
          if (step_q == STEP_W'(NSTEP - 1)) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign product   = acc_q;
endmodule
